// File: rtl/smalldiv_seq_if.sv
// Dividend/result handshake bundle for smalldiv_seq.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; the source
// holds valid and its payload stable until that edge, and ready never depends on valid.
interface smalldiv_seq_if #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVIDER_WIDTH  = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DIVIDEND_WIDTH-1:0] in_dividend;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIVIDEND_WIDTH-1:0] out_quotient;
  logic [DIVIDER_WIDTH-1:0]  out_remainder;

  modport master (
    output in_valid, in_dividend, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder
  );

  modport slave (
    input  in_valid, in_dividend, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder
  );
endinterface

// File: rtl/smalldiv_seq.sv
// Iterative unsigned divide by a small constant, one digit per cycle MSB-first,
// using a constant div/mod on {remainder, digit} instead of a multiplier.
module smalldiv_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIGIT_WIDTH    = 3,
  parameter int DIVIDER_VALUE  = 5,
  parameter int DIVIDER_WIDTH  = $clog2(DIVIDER_VALUE)
) (
  input  logic                clk,
  input  logic                srst,
  smalldiv_seq_if.slave       bus,
  output logic [1:0]          dbg_state
);

  localparam int NDIGITS = (DIVIDEND_WIDTH + DIGIT_WIDTH - 1) / DIGIT_WIDTH;
  localparam int PADW    = NDIGITS * DIGIT_WIDTH;
  localparam int IDXW    = DIVIDER_WIDTH + DIGIT_WIDTH;
  localparam int CNTW    = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [IDXW-1:0] DIV_C    = IDXW'(DIVIDER_VALUE);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NDIGITS - 1);

  if (DIVIDER_VALUE < 2) begin : g_bad_divider
    $error("smalldiv_seq: DIVIDER_VALUE must be >= 2");
  end
  if (DIVIDER_WIDTH > DIGIT_WIDTH) begin : g_bad_digit
    $error("smalldiv_seq: DIVIDER_WIDTH must not exceed DIGIT_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [PADW-1:0]          sh_q;
  logic [PADW-1:0]          qsr_q;
  logic [DIVIDER_WIDTH-1:0] rem_q;
  logic [CNTW-1:0]          cnt_q;

  logic [IDXW-1:0]          idx;
  logic [DIGIT_WIDTH-1:0]   q_digit;
  logic [DIVIDER_WIDTH-1:0] rem_next;
  logic [PADW-1:0]          qsr_next;

  // idx < DIVIDER_VALUE * 2^DIGIT_WIDTH, so the digit quotient fits in DIGIT_WIDTH bits.
  always_comb begin
    idx      = {rem_q, sh_q[PADW-1 -: DIGIT_WIDTH]};
    q_digit  = DIGIT_WIDTH'(idx / DIV_C);
    rem_next = DIVIDER_WIDTH'(idx % DIV_C);
    qsr_next = PADW'({qsr_q, q_digit});
  end

  always_comb begin
    state_d      = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q           <= IDLE;
      sh_q              <= '0;
      qsr_q             <= '0;
      rem_q             <= '0;
      cnt_q             <= '0;
      bus.out_quotient  <= '0;
      bus.out_remainder <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            sh_q  <= PADW'(bus.in_dividend);
            qsr_q <= '0;
            rem_q <= '0;
            cnt_q <= CNT_LAST;
          end
        end
        BUSY: begin
          rem_q <= rem_next;
          qsr_q <= qsr_next;
          sh_q  <= sh_q << DIGIT_WIDTH;
          if (cnt_q == '0) begin
            bus.out_quotient  <= qsr_next[DIVIDEND_WIDTH-1:0];
            bus.out_remainder <= rem_next;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule
